// File: rtl/sysbus_mem_responder.sv
// Memory-side responder for the Sysbus request/response protocol.
// Serves one 64-byte line per request: 8-beat READ bursts after a fixed latency, 8-beat WRITE absorption.
module sysbus_mem_responder #(
    parameter int LINES   = 1024,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqcyc,
    input  logic [63:0]      req,
    input  logic [TAG_W-1:0] reqtag,
    output logic             reqack,
    output logic             respcyc,
    output logic [63:0]      resp,
    output logic [TAG_W-1:0] resptag,
    input  logic             respack
);
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [2:0] {IDLE, ACK, WAIT, RESP, WR_DATA} state_e;

    state_e           state_q;
    logic [LW-1:0]    line_q;
    logic             oob_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       beat_q;
    logic [CW-1:0]    cnt_q;
    logic             reqack_q;
    logic             respcyc_q;
    logic [63:0]      resp_q;
    logic [TAG_W-1:0] resptag_q;

    logic [63:0] mem_q [LINES*8];

    logic [2:0]  beat_d;
    logic [2:0]  rd_beat_d;
    logic [63:0] rd_data_d;
    logic        wr_en_d;

    // The read port looks one beat ahead so resp_q is loaded with the beat about to be presented.
    assign beat_d    = beat_q + 3'd1;
    assign rd_beat_d = (state_q == RESP) ? beat_d : 3'd0;
    assign rd_data_d = oob_q ? 64'd0 : mem_q[{line_q, rd_beat_d}];
    assign wr_en_d   = (state_q == WR_DATA) && reqcyc && !oob_q;

    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[{line_q, beat_q}] <= req;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            line_q    <= '0;
            oob_q     <= 1'b0;
            tag_q     <= '0;
            beat_q    <= 3'd0;
            cnt_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= 64'd0;
            resptag_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqcyc) begin
                        line_q   <= req[6 +: LW];
                        oob_q    <= (req[63:6] >= 58'(LINES));
                        tag_q    <= reqtag;
                        reqack_q <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    beat_q <= 3'd0;
                    if (tag_q[TAG_W-1]) begin
                        reqack_q <= 1'b0;
                        cnt_q    <= CW'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state_q   <= RESP;
                            respcyc_q <= 1'b1;
                            resp_q    <= rd_data_d;
                            resptag_q <= tag_q;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else begin
                        state_q <= WR_DATA;
                    end
                end
                WAIT: begin
                    // cnt_q counts cycles still to go before the first beat is visible.
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= RESP;
                        respcyc_q <= 1'b1;
                        resp_q    <= rd_data_d;
                        resptag_q <= tag_q;
                    end
                end
                RESP: begin
                    if (respack) begin
                        if (beat_q == 3'd7) begin
                            state_q   <= IDLE;
                            respcyc_q <= 1'b0;
                            resp_q    <= 64'd0;
                            resptag_q <= '0;
                        end else begin
                            beat_q <= beat_d;
                            resp_q <= rd_data_d;
                        end
                    end
                end
                WR_DATA: begin
                    if (reqcyc) begin
                        beat_q <= beat_d;
                        if (beat_q == 3'd7) begin
                            state_q  <= IDLE;
                            reqack_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reqack  = reqack_q;
    assign respcyc = respcyc_q;
    assign resp    = resp_q;
    assign resptag = resptag_q;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: directed table, hand-written corner sequences, then random traffic
// checked against a line-addressed reference memory.
module tb_sysbus_mem_responder;
    localparam int LINES = 1024;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respack;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] mdl [longint];

    typedef struct packed {
        bit               rd;
        logic [63:0]      addr;
        logic [12:0]      tag;
        logic [7:0][63:0] d;
        logic [7:0]       bub;
        logic [3:0]       sb;
        logic [3:0]       sl;
    } vec_t;

    vec_t tbl [11];

    sysbus_mem_responder #(.LINES(LINES), .LATENCY(LAT), .TAG_W(13)) dut (
        .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
        .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag), .respack(respack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within its time budget");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0][63:0] exp_line(logic [63:0] addr);
        logic [7:0][63:0] r;
        longint ln;
        r  = '0;
        ln = longint'(addr >> 6);
        if (ln < LINES) begin
            for (int b = 0; b < 8; b++) begin
                r[b] = mdl.exists(ln * 8 + b) ? mdl[ln * 8 + b] : 64'hx;
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(bit rd, logic [63:0] addr, logic [12:0] tag, logic [7:0][63:0] d,
                                logic [7:0] bub, logic [3:0] sb, logic [3:0] sl);
        vec_t v;
        v.rd = rd; v.addr = addr; v.tag = tag; v.d = d; v.bub = bub; v.sb = sb; v.sl = sl;
        return v;
    endfunction

    task automatic issue(logic [63:0] addr, logic [12:0] tag, string nm);
        reqcyc = 1'b1; req = addr; reqtag = tag;
        step();
        reqcyc = 1'b0; req = '0;
        chk({nm, ".ack"}, reqack, 1'b1);
    endtask

    task automatic read_body(logic [12:0] tag, logic [7:0][63:0] exp, int sb, int sl, string nm);
        for (int c = 1; c <= LAT; c++) begin
            step();
            chk($sformatf("%s.lat%0d", nm, c), respcyc, (c == LAT));
            if (c == 1) chk({nm, ".ackdrop"}, reqack, 1'b0);
        end
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("%s.beat%0d", nm, b), resp, exp[b]);
            chk($sformatf("%s.tag%0d", nm, b), resptag, tag);
            if (b == sb) begin
                for (int s = 0; s < sl; s++) begin
                    respack = 1'b0;
                    step();
                    chk($sformatf("%s.stallcyc%0d", nm, s), respcyc, 1'b1);
                    chk($sformatf("%s.stallbeat%0d", nm, s), resp, exp[b]);
                end
            end
            respack = 1'b1;
            step();
            respack = 1'b0;
        end
        chk({nm, ".end"}, respcyc, 1'b0);
    endtask

    task automatic do_read(logic [63:0] addr, logic [12:0] tag, logic [7:0][63:0] exp,
                           int sb, int sl, string nm);
        issue(addr, tag, nm);
        read_body(tag, exp, sb, sl, nm);
    endtask

    task automatic do_write(logic [63:0] addr, logic [12:0] tag, logic [7:0][63:0] d,
                            logic [7:0] bub, string nm);
        longint ln;
        issue(addr, tag, nm);
        step();
        chk({nm, ".wrlevel"}, reqack, 1'b1);
        for (int b = 0; b < 8; b++) begin
            if (bub[b]) begin
                reqcyc = 1'b0;
                step();
                chk($sformatf("%s.bubble%0d", nm, b), reqack, 1'b1);
            end
            reqcyc = 1'b1; req = d[b];
            step();
            reqcyc = 1'b0; req = '0;
            chk($sformatf("%s.wrack%0d", nm, b), reqack, (b < 7));
        end
        ln = longint'(addr >> 6);
        if (ln < LINES) begin
            for (int b = 0; b < 8; b++) mdl[ln * 8 + b] = d[b];
        end
    endtask

    initial begin
        logic [7:0][63:0] line_a, line_0, line_5, zeros, ones, rnd;
        logic [63:0] oob, addr;
        longint pool [6];
        int acks;

        for (int b = 0; b < 8; b++) begin
            line_a[b] = 64'(8'h11 * (b + 1));
            line_0[b] = 64'h0123_4567_89AB_CDE0 + 64'(b);
            line_5[b] = ~line_0[b];
        end
        zeros = '0;
        ones  = '1;
        oob   = 64'(LINES + 5) << 6;

        tbl[0]  = mk(1'b0, 64'h1000,       13'h0101, line_a, 8'h00,       4'd8, 4'd0);
        tbl[1]  = mk(1'b1, 64'h1000,       13'h1142, line_a, 8'h00,       4'd8, 4'd0);
        tbl[2]  = mk(1'b1, 64'h1038,       13'h1143, line_a, 8'h00,       4'd8, 4'd0);
        tbl[3]  = mk(1'b0, 64'h0000,       13'h0003, line_0, 8'b0010_0100, 4'd8, 4'd0);
        tbl[4]  = mk(1'b0, 64'h0140,       13'h0A04, line_5, 8'h00,       4'd8, 4'd0);
        tbl[5]  = mk(1'b1, 64'h0140,       13'h1F05, line_5, 8'h00,       4'd2, 4'd3);
        tbl[6]  = mk(1'b1, oob,            13'h1106, zeros,  8'h00,       4'd8, 4'd0);
        tbl[7]  = mk(1'b0, oob,            13'h0107, ones,   8'h81,       4'd8, 4'd0);
        tbl[8]  = mk(1'b1, 64'h0000,       13'h1108, line_0, 8'h00,       4'd8, 4'd0);
        tbl[9]  = mk(1'b1, 64'h0140,       13'h1109, line_5, 8'h00,       4'd8, 4'd0);
        tbl[10] = mk(1'b1, oob | 64'h2A,   13'h110A, zeros,  8'h00,       4'd8, 4'd0);

        reset = 1'b0; reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
        step(); step();
        chk("rst.reqack", reqack, 1'b0);
        chk("rst.respcyc", respcyc, 1'b0);
        chk("rst.resp", resp, 64'd0);
        chk("rst.resptag", resptag, 13'd0);
        reset = 1'b1;
        step();
        chk("idle.reqack", reqack, 1'b0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rd)
                do_read(tbl[i].addr, tbl[i].tag, tbl[i].d, tbl[i].sb, tbl[i].sl, $sformatf("vec%0d", i));
            else
                do_write(tbl[i].addr, tbl[i].tag, tbl[i].d, tbl[i].bub, $sformatf("vec%0d", i));
        end

        // reqcyc left high through the whole read: only one acceptance until the bus is idle again
        reqcyc = 1'b1; req = 64'h1000; reqtag = 13'h1177;
        step();
        chk("held.ack", reqack, 1'b1);
        acks = 0;
        for (int c = 1; c <= LAT; c++) begin
            step();
            acks += int'(reqack);
        end
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("held.beat%0d", b), resp, line_a[b]);
            respack = 1'b1;
            step();
            acks += int'(reqack);
        end
        respack = 1'b0;
        chk("held.extra_acks", acks, 0);
        chk("held.idle_gap", respcyc, 1'b0);
        step();
        chk("held.reaccept", reqack, 1'b1);
        reqcyc = 1'b0; req = '0;
        read_body(13'h1177, line_a, 8, 0, "held2");

        // reset asserted while beat 4 is on the bus
        issue(64'h1000, 13'h1188, "rstmid");
        for (int c = 1; c <= LAT; c++) step();
        for (int b = 0; b < 4; b++) begin
            respack = 1'b1;
            step();
        end
        respack = 1'b0;
        chk("rstmid.beat4", resp, line_a[4]);
        #2 reset = 1'b0;
        #1;
        chk("rstmid.respcyc", respcyc, 1'b0);
        chk("rstmid.resp", resp, 64'd0);
        #3 reset = 1'b1;
        step();
        chk("rstmid.after", respcyc, 1'b0);
        do_read(64'h1000, 13'h11AA, line_a, 8, 0, "rstmid.rd");

        pool[0] = 64; pool[1] = 65; pool[2] = 1023; pool[3] = 512; pool[4] = 7; pool[5] = 256;
        for (int p = 0; p < 6; p++) begin
            for (int b = 0; b < 8; b++) rnd[b] = {$urandom, $urandom};
            do_write(64'(pool[p]) << 6, {1'b0, 4'($urandom), 8'($urandom)}, rnd,
                     8'($urandom) & 8'h55, $sformatf("rinit%0d", p));
        end
        for (int n = 0; n < 40; n++) begin
            int op, p;
            op = $urandom_range(0, 9);
            p  = $urandom_range(0, 5);
            addr = (64'(pool[p]) << 6) | 64'($urandom_range(0, 63));
            if (op >= 7) addr = addr + (64'(LINES * $urandom_range(1, 50)) << 6);
            if (op == 4 || op == 5 || op == 6 || op == 8) begin
                for (int b = 0; b < 8; b++) rnd[b] = {$urandom, $urandom};
                do_write(addr, {1'b0, 4'($urandom), 8'($urandom)}, rnd, 8'($urandom),
                         $sformatf("rnd%0d.wr", n));
            end else begin
                do_read(addr, {1'b1, 4'($urandom), 8'($urandom)}, exp_line(addr),
                        $urandom_range(0, 7), $urandom_range(0, 3), $sformatf("rnd%0d.rd", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
